// File: rtl/fft_disp_sched_if.sv
// FFT result stream into the display scheduler: run control pulses and the current output bin.
interface fft_disp_sched_if #(
    parameter int BW = 34
) ();
    logic                 en_FFT;
    logic                 finish_FFT;
    logic                 en_comp;
    logic                 done_all;
    logic signed [BW-1:0] Re_in;
    logic signed [BW-1:0] Im_in;

    modport master (
        output en_FFT, finish_FFT, en_comp, done_all, Re_in, Im_in
    );

    modport slave (
        input en_FFT, finish_FFT, en_comp, done_all, Re_in, Im_in
    );
endinterface

// File: rtl/fft_disp_sched.sv
// FFT demo display scheduler: BCD run timer, peak-bin tracker, key debounce, 4-digit scan.
// Optional macro PEAK_HOLD_EN keeps the peak across runs; key[1] press (or reset) clears it.
//
// state   | meaning
// IDLE    | no run since reset
// TIMING  | run in progress, time BCD counting up
// COLLECT | FFT finished, bins streaming, time frozen
// DONE    | all results held until the next en_FFT
module fft_disp_sched #(
    parameter int BW       = 34,
    parameter int N        = 32,
    parameter int DEB_CYC  = 999999,
    parameter int SCAN_CYC = 1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      key,
    fft_disp_sched_if.slave fft,
    output logic [3:0]      dig,
    output logic [3:0]      digit,
    output logic [3:0]      led,
    output logic            busy
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_TIMING  = 2'd1;
    localparam logic [1:0] S_COLLECT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int SW = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
    localparam int NW = (N > 1) ? $clog2(N) : 1;

    localparam logic [DW-1:0] DEB_LOAD  = DW'(DEB_CYC - 1);
    localparam logic [SW-1:0] SCAN_LOAD = SW'(SCAN_CYC - 1);
    localparam logic [NW-1:0] LAST_BIN  = NW'(N - 1);
    localparam logic [15:0]   BCD_MAX   = 16'h9999;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic [1:0]    state;
    logic [15:0]   time_bcd;
    logic [15:0]   bin_bcd;
    logic [NW-1:0] bin_cnt;
    logic [15:0]   peak_bin;
    logic [16:0]   peak_mag;
    logic          run;
    logic          bin_ok;
    logic          last_bin;

    logic signed [7:0]  re8;
    logic signed [7:0]  im8;
    logic signed [15:0] re_sq;
    logic signed [15:0] im_sq;
    logic [16:0]        mag;
    logic               unused_lsbs;

    assign re8         = fft.Re_in[BW-1 -: 8];
    assign im8         = fft.Im_in[BW-1 -: 8];
    assign re_sq       = re8 * re8;
    assign im_sq       = im8 * im8;
    assign mag         = {1'b0, re_sq} + {1'b0, im_sq};
    assign unused_lsbs = ^{fft.Re_in[BW-9:0], fft.Im_in[BW-9:0]};

    assign run      = (state == S_TIMING) || (state == S_COLLECT);
    assign bin_ok   = run && fft.en_comp;
    assign last_bin = bin_ok && (bin_cnt == LAST_BIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else if (fft.en_FFT) begin
            state <= S_TIMING;
        end else begin
            case (state)
                S_TIMING:  if (fft.finish_FFT) state <= S_COLLECT;
                S_COLLECT: if (fft.done_all || last_bin) state <= S_DONE;
                default:   state <= state;
            endcase
        end
    end

    // The finish_FFT cycle itself is not counted: time freezes on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_bcd <= '0;
        end else if (fft.en_FFT) begin
            time_bcd <= '0;
        end else if (state == S_TIMING && !fft.finish_FFT && time_bcd != BCD_MAX) begin
            time_bcd <= bcd_inc(time_bcd);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_bcd <= '0;
            bin_cnt <= '0;
        end else if (fft.en_FFT) begin
            bin_bcd <= '0;
            bin_cnt <= '0;
        end else if (bin_ok) begin
            if (bin_bcd != BCD_MAX) bin_bcd <= bcd_inc(bin_bcd);
            bin_cnt <= bin_cnt + NW'(1);
        end
    end

    logic [1:0] key_s1;
    logic [1:0] key_s2;
    logic [1:0] press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1 <= 2'b11;
            key_s2 <= 2'b11;
        end else begin
            key_s1 <= key;
            key_s2 <= key_s1;
        end
    end

    // A differing sample reloads nothing; DEB_CYC differing samples in a row flip the state.
    for (genvar g = 0; g < 2; g++) begin : g_key
        logic [DW-1:0] cnt;
        logic          stable;
        logic          pulse;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt    <= DEB_LOAD;
                stable <= 1'b1;
                pulse  <= 1'b0;
            end else begin
                pulse <= 1'b0;
                if (key_s2[g] == stable) begin
                    cnt <= DEB_LOAD;
                end else if (cnt == '0) begin
                    stable <= key_s2[g];
                    cnt    <= DEB_LOAD;
                    pulse  <= ~key_s2[g];
                end else begin
                    cnt <= cnt - DW'(1);
                end
            end
        end

        assign press[g] = pulse;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_bin <= '0;
            peak_mag <= '0;
`ifdef PEAK_HOLD_EN
        end else if (press[1]) begin
            peak_bin <= '0;
            peak_mag <= '0;
        end else if (bin_ok && !fft.en_FFT && mag > peak_mag) begin
            peak_bin <= bin_bcd;
            peak_mag <= mag;
        end
`else
        end else if (fft.en_FFT) begin
            peak_bin <= '0;
            peak_mag <= '0;
        end else if (bin_ok && mag > peak_mag) begin
            peak_bin <= bin_bcd;
            peak_mag <= mag;
        end
`endif
    end

    logic [2:0] mode;
    logic       blank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode  <= 3'b001;
            blank <= 1'b0;
        end else begin
            if (press[0]) mode <= {mode[1:0], mode[2]};
            if (press[1]) blank <= ~blank;
        end
    end

    logic [SW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic [15:0]   src;
    logic [3:0]    nib;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= SCAN_LOAD;
            idx      <= 2'd0;
        end else if (scan_cnt == '0) begin
            scan_cnt <= SCAN_LOAD;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt - SW'(1);
        end
    end

    always_comb begin
        src = time_bcd;
        case (mode)
            3'b010:  src = peak_bin;
            3'b100:  src = peak_mag[16:1];
            default: src = time_bcd;
        endcase
        nib = src[{idx, 2'b00} +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig   <= 4'b1111;
            digit <= 4'd0;
        end else begin
            dig   <= blank ? 4'b1111 : ~(4'b0001 << idx);
            digit <= nib;
        end
    end

    assign busy = run;
    assign led  = {run, blank ? 3'b000 : mode};
endmodule

// File: tb/tb_fft_disp_sched.sv
// Self-checking bench for fft_disp_sched: vector table, directed corner sequences, random runs vs a peak/time model.
module tb_fft_disp_sched;
    localparam int BW       = 34;
    localparam int N        = 32;
    localparam int DEB_CYC  = 10;
    localparam int SCAN_CYC = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] key   = 2'b11;
    logic [3:0] dig;
    logic [3:0] digit;
    logic [3:0] led;
    logic       busy;

    fft_disp_sched_if #(.BW(BW)) fft ();

    fft_disp_sched #(
        .BW(BW), .N(N), .DEB_CYC(DEB_CYC), .SCAN_CYC(SCAN_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .fft(fft),
        .dig(dig), .digit(digit), .led(led), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model: mode 0=TIME 1=BIN 2=MAG, peak by strict-greater rule
    int m_mode;
    bit m_blank;
    int pk_mag;
    int pk_bin;

    typedef struct {
        int          re;
        int          im;
        logic [15:0] exp_disp;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] to_bcd(int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [3:0] exp_led(bit b);
        return {b, m_blank ? 3'b000 : 3'(1 << m_mode)};
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_blank = 0;
        pk_mag  = 0;
        pk_bin  = 0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        key   = 2'b11;
        fft.en_FFT = 0; fft.finish_FFT = 0; fft.en_comp = 0; fft.done_all = 0;
        ticks(2);
        rst_n = 1'b1;
        model_reset();
        ticks(1);
    endtask

    task automatic press(int k);
        key[k] = 1'b0;
        ticks(DEB_CYC + 4);
        key[k] = 1'b1;
        ticks(DEB_CYC + 4);
        if (k == 0) begin
            m_mode = (m_mode + 1) % 3;
        end else begin
            m_blank = !m_blank;
`ifdef PEAK_HOLD_EN
            pk_mag = 0;
            pk_bin = 0;
`endif
        end
    endtask

    task automatic set_mode(int t);
        for (int i = 0; i < 3 && m_mode != t; i++) press(0);
    endtask

    task automatic start_run();
        fft.en_FFT = 1;
        ticks(1);
        fft.en_FFT = 0;
`ifndef PEAK_HOLD_EN
        pk_mag = 0;
        pk_bin = 0;
`endif
    endtask

    task automatic pulse_finish();
        fft.finish_FFT = 1;
        ticks(1);
        fft.finish_FFT = 0;
    endtask

    task automatic pulse_done();
        fft.done_all = 1;
        ticks(1);
        fft.done_all = 0;
    endtask

    task automatic send_bin(int idx, int re, int im, bit done);
        logic [7:0] r8;
        logic [7:0] i8;
        int         m;
        r8 = 8'(re);
        i8 = 8'(im);
        fft.Re_in    = {r8, (BW-8)'($urandom)};
        fft.Im_in    = {i8, (BW-8)'($urandom)};
        fft.en_comp  = 1;
        fft.done_all = done;
        ticks(1);
        fft.en_comp  = 0;
        fft.done_all = 0;
        m = re * re + im * im;
        if (m > pk_mag) begin
            pk_mag = m;
            pk_bin = idx;
        end
    endtask

    task automatic read_disp(output logic [15:0] v);
        logic [3:0] seen;
        logic [3:0] pat;
        seen = 4'h0;
        v    = 16'h0;
        ticks(2);
        for (int c = 0; c < 64 && seen != 4'hF; c++) begin
            for (int i = 0; i < 4; i++) begin
                pat = ~(4'(1) << i);
                if (dig == pat) begin
                    v[i*4 +: 4] = digit;
                    seen[i]     = 1'b1;
                end
            end
            ticks(1);
        end
        chk("disp_scan_complete", seen, 4'hF);
    endtask

    initial begin
        logic [15:0] v;
        logic [3:0]  pat;
        int          first;
        int          len;
        int          nb;
        bit          dn;

        tbl[0] = '{re:    0, im:    0, exp_disp: 16'h0000};
        tbl[1] = '{re:   -1, im:    0, exp_disp: 16'h0000};
        tbl[2] = '{re:    1, im:    1, exp_disp: 16'h0001};
        tbl[3] = '{re:    3, im:    4, exp_disp: 16'h000C};
        tbl[4] = '{re:   -7, im:    0, exp_disp: 16'h0018};
        tbl[5] = '{re:  127, im:  127, exp_disp: 16'h3F01};
        tbl[6] = '{re: -128, im:  127, exp_disp: 16'h3F80};
        tbl[7] = '{re: -128, im: -128, exp_disp: 16'h4000};

        fft.en_FFT = 0; fft.finish_FFT = 0; fft.en_comp = 0; fft.done_all = 0;
        fft.Re_in = '0; fft.Im_in = '0;
        model_reset();

        // reset values
        rst_n = 1'b0;
        ticks(2);
        chk("rst_dig", dig, 4'b1111);
        chk("rst_digit", digit, 4'd0);
        chk("rst_led", led, 4'b0001);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        ticks(1);

        // magnitude table, one bin per run; mags increase so hold builds agree
        set_mode(2);
        for (int t = 0; t < 8; t++) begin
            start_run();
            ticks(3);
            pulse_finish();
            send_bin(0, tbl[t].re, tbl[t].im, 1'b1);
            chk("tbl_busy", busy, 1'b0);
            read_disp(v);
            chk($sformatf("tbl_mag_%0d", t), v, tbl[t].exp_disp);
        end

        // 1234-cycle run, frozen afterwards
        reset_dut();
        start_run();
        chk("run_busy", busy, 1'b1);
        ticks(1234);
        pulse_finish();
        chk("collect_led", led, 4'b1001);
        pulse_done();
        chk("done_busy", busy, 1'b0);
        read_disp(v);
        chk("time_1234", v, 16'h1234);
        ticks(100);
        read_disp(v);
        chk("time_frozen", v, 16'h1234);

        // saturation
        start_run();
        ticks(12000);
        pulse_finish();
        pulse_done();
        read_disp(v);
        chk("time_sat", v, 16'h9999);

        // 32 bins, ending on N-th acceptance
        reset_dut();
        start_run();
        ticks(5);
        pulse_finish();
        for (int b = 0; b < N; b++) begin
            ticks($urandom_range(0, 2));
            if (b == 5)       send_bin(b, 3, 4, 1'b0);
            else if (b == 9)  send_bin(b, -7, 0, 1'b0);
            else if (b == 20) send_bin(b, 0, -7, 1'b0);
            else              send_bin(b, 0, 0, 1'b0);
        end
        chk("nth_bin_done", busy, 1'b0);
        fft.Re_in = {8'h80, 26'h0};
        fft.Im_in = {8'h80, 26'h0};
        fft.en_comp = 1;
        ticks(1);
        fft.en_comp = 0;
        set_mode(1);
        chk("bin_led", led, 4'b0010);
        read_disp(v);
        chk("peak_bin", v, 16'h0009);
        set_mode(2);
        chk("mag_led", led, 4'b0100);
        read_disp(v);
        chk("peak_mag", v, 16'h0018);

        // debounce and blanking
        reset_dut();
        key[0] = 1'b0;
        ticks(5);
        key[0] = 1'b1;
        ticks(DEB_CYC + 4);
        chk("glitch_led", led, 4'b0001);
        press(0);
        chk("press1_led", led, 4'b0010);
        press(0);
        chk("press2_led", led, 4'b0100);
        press(1);
        chk("blank_led", led, 4'b0000);
        first = 0;
        for (int c = 0; c < 12; c++) begin
            if (dig != 4'b1111) first++;
            ticks(1);
        end
        chk("blank_dig_cycles_lit", first, 0);
        press(1);
        chk("unblank_led", led, exp_led(1'b0));
        read_disp(v);
        chk("unblank_mag", v, 16'(pk_mag >> 1));

        // restart mid-COLLECT
        reset_dut();
        start_run();
        ticks(4);
        pulse_finish();
        send_bin(0, 0, 0, 1'b0);
        send_bin(1, 0, 0, 1'b0);
        send_bin(2, 0, 0, 1'b0);
        send_bin(3, 10, 0, 1'b0);
        start_run();
        pulse_finish();
        chk("restart_busy", busy, 1'b1);
        read_disp(v);
        chk("restart_time", v, 16'h0000);
        set_mode(2);
        read_disp(v);
`ifdef PEAK_HOLD_EN
        chk("restart_peak", v, 16'h0032);
`else
        chk("restart_peak", v, 16'h0000);
`endif

        // en_FFT beats finish_FFT and done_all
        set_mode(0);
        start_run();
        ticks(5);
        fft.en_FFT = 1;
        fft.finish_FFT = 1;
        ticks(1);
        fft.en_FFT = 0;
        fft.finish_FFT = 0;
        chk("en_beats_finish_busy", busy, 1'b1);
        ticks(7);
        pulse_finish();
        fft.en_FFT = 1;
        fft.done_all = 1;
        ticks(1);
        fft.en_FFT = 0;
        fft.done_all = 0;
        chk("en_beats_done_busy", busy, 1'b1);
        ticks(6);
        pulse_finish();
        pulse_done();
        read_disp(v);
        chk("en_beats_time", v, 16'h0006);

        // randomized runs against the model
        reset_dut();
        for (int r = 0; r < 15; r++) begin
            len = $urandom_range(0, 300);
            nb  = $urandom_range(1, N);
            dn  = 1'b0;
            start_run();
            ticks(len);
            pulse_finish();
            for (int b = 0; b < nb; b++) begin
                ticks($urandom_range(0, 2));
                dn = (b == nb - 1) && (nb < N) && ($urandom_range(0, 1) == 1);
                send_bin(b, int'($urandom_range(0, 12)) - 6, int'($urandom_range(0, 12)) - 6, dn);
            end
            if (nb < N && !dn) pulse_done();
            chk("rnd_busy", busy, 1'b0);
            set_mode(0);
            chk("rnd_led", led, exp_led(1'b0));
            read_disp(v);
            chk("rnd_time", v, to_bcd(len));
            set_mode(1);
            read_disp(v);
            chk("rnd_bin", v, to_bcd(pk_bin));
            set_mode(2);
            read_disp(v);
            chk("rnd_mag", v, 16'(pk_mag >> 1));
        end

        // digit scan order and dwell, then async reset mid-dwell
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        model_reset();
        first = -1;
        for (int c = 0; c < 10 && first < 0; c++) begin
            ticks(1);
            if (dig != 4'b1111) first = c;
        end
        chk("scan_started", (first >= 0), 1'b1);
        for (int k = 0; k < 16; k++) begin
            pat = ~(4'(1) << ((k / SCAN_CYC) % 4));
            chk("scan_seq", dig, pat);
            ticks(1);
        end
        press(0);
        start_run();
        ticks(3);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_dig", dig, 4'b1111);
        chk("async_rst_digit", digit, 4'd0);
        chk("async_rst_led", led, 4'b0001);
        chk("async_rst_busy", busy, 1'b0);
        ticks(1);
        rst_n = 1'b1;
        ticks(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fft_disp_sched.md
Name: fft_disp_sched

Overview:
Display scheduler/controller for the FFT board demo. It times each FFT run in clock cycles, using a BCD counter. It tracks the peak-magnitude output bin from the streamed FFT results. It debounces the two user keys to select what is shown. It time-multiplexes four nibbles onto the 4-digit display; a downstream 7-segment decoder converts `digit` to segment patterns.

Parameters:
BW, 34, width of signed Re_in/Im_in FFT outputs
N, 32, FFT points (bins per run), N <= 9999
DEB_CYC, 999999, key debounce stable-time in clk cycles (20 ms @ 50 MHz)
SCAN_CYC, 1000, dwell time per display digit in clk cycles

Ports:
clk  in  1  system clock
rst_n  in  1  reset
key  in  2  raw push-buttons, active-low (1 = released)
en_FFT  in  1  1-cycle pulse, FFT run start
finish_FFT  in  1  1-cycle pulse, FFT computation finished
en_comp  in  1  Re_in/Im_in hold a valid output bin this cycle
done_all  in  1  1-cycle pulse, all bins streamed out
Re_in  in  BW  signed real part of current bin
Im_in  in  BW  signed imaginary part of current bin
dig  out  4  digit enables, active-low, one-hot zero
digit  out  4  nibble for the enabled digit
led  out  4  {busy, mode one-hot[2:0]}
busy  out  1  high in TIMING or COLLECT

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All state is cleared on reset, including mid-run.
- Reset values: dig=4'b1111, digit=0, led=4'b0001, busy=0, FSM=IDLE, mode=TIME, time BCD=0000, peak bin=0000, peak mag=0.
- FSM states: IDLE, TIMING, COLLECT, DONE.
  - IDLE / DONE, en_FFT -> TIMING. On entry: clear time BCD, bin BCD counter, peak bin and peak mag.
  - TIMING: time BCD increments by 1 each clk. Four digits, each 0-9 with carry. Saturates at 9999; no wrap. finish_FFT -> COLLECT, and time is frozen.
  - COLLECT: time frozen. done_all, or acceptance of the N-th bin -> DONE.
  - DONE: all results held until the next en_FFT.
  - en_FFT in TIMING or COLLECT restarts the run (-> TIMING, cleared). en_FFT beats finish_FFT/done_all in the same cycle.
- Bin processing: active in TIMING and COLLECT when en_comp=1.
  - re8 = Re_in[BW-1:BW-8], im8 = Im_in[BW-1:BW-8].
  - mag = re8*re8 + im8*im8, 17-bit unsigned, computed combinationally from the current inputs.
  - If mag > peak_mag (strict; ties keep the earlier bin), set peak_mag <= mag and peak_bin <= current bin BCD.
  - The bin BCD counter then increments; the first bin is 0000.
  - en_comp together with done_all: the bin is processed, then DONE.
  - en_comp outside TIMING/COLLECT is ignored.
- Keys: 2-FF synchroniser. Per key, the state is accepted after DEB_CYC consecutive equal samples. A press is the debounced 1->0 edge, one event.
  - key[0] press cycles mode TIME -> BIN -> MAG -> TIME.
  - key[1] press toggles blank. While blank: dig=1111, led[2:0]=000, and mode is retained.
- Display sources:
  - TIME: time BCD digits 3..0.
  - BIN: peak_bin BCD.
  - MAG: peak_mag[16:1] as 4 hex nibbles.
- Digit scan: dwell counter 0..SCAN_CYC-1, then idx advances 0->1->2->3->0.
  - dig = ~(1<<idx), registered; digit = selected nibble for idx (idx 0 = least significant), registered in the same cycle.
  - Display changes take effect at the next dig refresh; no mid-dwell glitch requirement.
- led[3] = busy; led[2:0] = one-hot mode (TIME=001, BIN=010, MAG=100).

Optional Feature:
PEAK_HOLD_EN
- Defined: peak_mag/peak_bin are not cleared on en_FFT. They hold the maximum across runs and are cleared only by reset or a key[1] press; key[1] still toggles blank.
- Undefined: peak cleared at every en_FFT as specified above.

Test Plan:
1. Reset, en_FFT, 1234 cycles, then finish_FFT -> TIME digits show 1,2,3,4 (msd..lsd); busy=0 after done_all; time stays frozen afterwards.
2. Run of 12000 cycles before finish_FFT -> time saturates at 9999, no wrap.
3. N=32 bins streamed; bin 5 has re8=3,im8=4 (mag 25), bin 9 has re8=-7,im8=0 (mag 49), bin 20 has mag 49, all others 0 -> BIN mode shows 0009; MAG mode shows 0018 hex (49>>1=24=0x18).
4. DEB_CYC=10: key[0] low for 5 cycles -> no mode change. Low for 12 cycles -> mode BIN, led=0010. Second valid press -> MAG. Then key[1] press -> dig=1111.
5. en_FFT pulsed mid-COLLECT after bin 3 (mag 100) -> peak_mag=0 and time=0 next cycle. Same test with PEAK_HOLD_EN -> peak retained at 100.
6. SCAN_CYC=4 -> dig sequence 1110,1101,1011,0111, each held 4 cycles; rst_n asserted mid-scan -> dig=1111 immediately.
